// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart_tx serializer among NUM_REQ byte sources.
//   i_Clock/i_Reset          : clock, asynchronous active-high reset
//   i_Req_Valid/Byte/Last    : per-requester byte offer (byte k at [8k+7:8k])
//   o_Req_Ready              : one-hot accept strobe to the owner
//   o_Grant/o_Busy/o_Timeout : current owner, non-idle flag, lock-revoke pulse
//   o_Tx_DV/o_Tx_Byte        : serializer load strobe and byte
//   i_Tx_Active/i_Tx_Done    : serializer status
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDX_W        = 2,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Busy,
    output logic                 o_Timeout,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE, S_HOLD} state_t;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d, ptr_q, ptr_d, pick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d, tx_dv_q, tx_dv_d, timeout_q, timeout_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             found, owner_valid, cnt_max, start;

    assign owner_valid = i_Req_Valid[owner_q];
    assign cnt_max     = cnt_q == CNT_W'(LOCK_TIMEOUT - 1);
    assign start       = found && !i_Tx_Active;

    // First valid requester strictly after the pointer, wrapping around.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && i_Req_Valid[IDX_W'((int'(ptr_q) + i) % NUM_REQ)]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            last_q    <= 1'b0;
            tx_dv_q   <= 1'b0;
            timeout_q <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            tx_dv_q   <= tx_dv_d;
            timeout_q <= timeout_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = start ? S_SEND : S_IDLE;
            S_SEND:      state_d = owner_valid ? S_WAIT_DONE : S_HOLD;
            S_WAIT_DONE: state_d = !i_Tx_Done ? S_WAIT_DONE : last_q ? S_IDLE : S_HOLD;
            S_HOLD:      state_d = owner_valid ? S_SEND : cnt_max ? S_IDLE : S_HOLD;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            S_SEND: begin
                if (owner_valid) begin
                    tx_byte_d = i_Req_Byte[{owner_q, 3'b000} +: 8];
                    last_d    = i_Req_Last[owner_q];
                    tx_dv_d   = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done && last_q) ptr_d = owner_q;
                if (i_Tx_Done && !last_q) cnt_d = '0;
            end
            S_HOLD: begin
                if (!owner_valid && cnt_max) begin
                    timeout_d = 1'b1;
                    ptr_d     = owner_q;
                end
                if (!owner_valid && !cnt_max) cnt_d = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        o_Busy      = state_q != S_IDLE;
        o_Grant     = o_Busy ? NUM_REQ'(1) << owner_q : '0;
        o_Req_Ready = (state_q == S_SEND && owner_valid) ? o_Grant : '0;
        o_Timeout   = timeout_q;
        o_Tx_DV     = tx_dv_q;
        o_Tx_Byte   = tx_byte_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, packet lock, timeout and reset behaviour.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_byte;
    logic        busy, timeout, tx_dv, tx_active, tx_done;
    logic [7:0]  tx_byte;

    logic [8:0]  rmem [4][16];
    logic [3:0]  rhead [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0]  rtail [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0]  force_off = 4'd0;
    logic        act_force = 1'b0;
    logic        m_active;
    int          m_cnt;
    int          cyc = 0;
    logic [7:0]  sent [$];
    int          dv_cyc [$];
    int          done_cyc [$];
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [3:0] valid;
        logic       act;
        logic [3:0] grant;
        logic       busy;
    } vec_t;
    vec_t tbl [10];

    uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .LOCK_TIMEOUT(8)) dut (
        .i_Clock(clk), .i_Reset(rst),
        .i_Req_Valid(req_valid), .i_Req_Byte(req_byte), .i_Req_Last(req_last),
        .o_Req_Ready(req_ready), .o_Grant(grant), .o_Busy(busy), .o_Timeout(timeout),
        .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
        .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: each presents the head of its byte queue and pops it when accepted.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            req_valid[k]        = (rhead[k] != rtail[k]) && !force_off[k];
            req_byte[8*k +: 8]  = rmem[k][rhead[k]][7:0];
            req_last[k]         = rmem[k][rhead[k]][8];
        end
    end
    always @(posedge clk)
        for (int k = 0; k < 4; k++)
            if (req_valid[k] && req_ready[k]) rhead[k] <= rhead[k] + 4'd1;

    // Serializer stand-in: 10 bits at 4 clocks per bit, then a one-cycle Done.
    assign tx_active = m_active | act_force;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt    <= 0;
            m_active <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_dv) begin
                m_cnt    <= 40;
                m_active <= 1'b1;
                sent.push_back(tx_byte);
                dv_cyc.push_back(cyc);
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    tx_done  <= 1'b1;
                    m_active <= 1'b0;
                    done_cyc.push_back(cyc + 1);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push(input int k, input logic last, input logic [7:0] b);
        rmem[k][rtail[k]] = {last, b};
        rtail[k] = rtail[k] + 4'd1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        force_off = 4'd0;
        act_force = 1'b0;
        for (int k = 0; k < 4; k++) rtail[k] = rhead[k];
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        while (!tx_done && t < 200) begin
            tick;
            t++;
        end
        chk({nm, "_done"}, 32'(tx_done), 32'd1);
    endtask

    task automatic wait_sent(input string nm, input int n);
        int t;
        t = 0;
        while (sent.size() < n && t < 3000) begin
            tick;
            t++;
        end
        chk({nm, "_count"}, sent.size(), n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bs, bv, bd;
        tbl[0] = '{4'b0001, 1'b0, 4'b0001, 1'b1};
        tbl[1] = '{4'b0010, 1'b0, 4'b0010, 1'b1};
        tbl[2] = '{4'b0100, 1'b0, 4'b0100, 1'b1};
        tbl[3] = '{4'b1000, 1'b0, 4'b1000, 1'b1};
        tbl[4] = '{4'b0110, 1'b0, 4'b0010, 1'b1};
        tbl[5] = '{4'b1100, 1'b0, 4'b0100, 1'b1};
        tbl[6] = '{4'b1111, 1'b0, 4'b0001, 1'b1};
        tbl[7] = '{4'b1001, 1'b0, 4'b0001, 1'b1};
        tbl[8] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[9] = '{4'b1111, 1'b1, 4'b0000, 1'b0};

        do_reset;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dv", 32'(tx_dv), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_reset;
            act_force = tbl[i].act;
            for (int k = 0; k < 4; k++)
                if (tbl[i].valid[k]) push(k, 1'b1, 8'(8'h80 + k));
            tick;
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].grant));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        end

        // Single byte with grant/DV latency and busy release.
        do_reset;
        bs = sent.size();
        push(0, 1'b1, 8'hA5);
        tick;
        chk("sb_grant", 32'(grant), 32'h1);
        chk("sb_ready", 32'(req_ready), 32'h1);
        chk("sb_dv_early", 32'(tx_dv), 32'd0);
        tick;
        chk("sb_dv", 32'(tx_dv), 32'd1);
        chk("sb_byte", 32'(tx_byte), 32'hA5);
        chk("sb_ready_off", 32'(req_ready), 32'd0);
        tick;
        chk("sb_dv_pulse", 32'(tx_dv), 32'd0);
        wait_done("sb");
        chk("sb_busy_at_done", 32'(busy), 32'd1);
        tick;
        chk("sb_busy_after", 32'(busy), 32'd0);
        chk("sb_grant_after", 32'(grant), 32'd0);
        chk("sb_sent", 32'(sent[bs]), 32'hA5);

        // Round robin with a repeat request from requester 0.
        do_reset;
        bs = sent.size();
        for (int k = 0; k < 4; k++) push(k, 1'b1, 8'(8'h10 + k));
        wait_sent("rr_first", bs + 1);
        push(0, 1'b1, 8'h20);
        wait_sent("rr_all", bs + 5);
        chk("rr_0", 32'(sent[bs]), 32'h10);
        chk("rr_1", 32'(sent[bs+1]), 32'h11);
        chk("rr_2", 32'(sent[bs+2]), 32'h12);
        chk("rr_3", 32'(sent[bs+3]), 32'h13);
        chk("rr_4", 32'(sent[bs+4]), 32'h20);

        // Packet lock against a contending requester, with inter-byte spacing.
        do_reset;
        bs = sent.size();
        bv = dv_cyc.size();
        bd = done_cyc.size();
        push(2, 1'b1, 8'h77);
        push(1, 1'b0, 8'h01);
        push(1, 1'b0, 8'h02);
        push(1, 1'b1, 8'h03);
        wait_sent("pl", bs + 4);
        chk("pl_0", 32'(sent[bs]), 32'h01);
        chk("pl_1", 32'(sent[bs+1]), 32'h02);
        chk("pl_2", 32'(sent[bs+2]), 32'h03);
        chk("pl_3", 32'(sent[bs+3]), 32'h77);
        chk("pl_gap1", dv_cyc[bv+1] - done_cyc[bd], 3);
        chk("pl_gap2", dv_cyc[bv+2] - done_cyc[bd+1], 3);
        chk("pl_gap3", dv_cyc[bv+3] - done_cyc[bd+2], 3);

        // Lock timeout after the owner stalls mid-packet.
        do_reset;
        bs = sent.size();
        push(0, 1'b0, 8'h55);
        push(3, 1'b1, 8'h33);
        tick;
        chk("to_grant0", 32'(grant), 32'h1);
        wait_done("to");
        for (int i = 1; i <= 8; i++) begin
            tick;
            chk($sformatf("to_quiet%0d", i), 32'(timeout), 32'd0);
        end
        chk("to_held", 32'(grant), 32'h1);
        tick;
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_grant_drop", 32'(grant), 32'd0);
        chk("to_busy_drop", 32'(busy), 32'd0);
        tick;
        chk("to_pulse_end", 32'(timeout), 32'd0);
        chk("to_grant3", 32'(grant), 32'h8);
        wait_sent("to", bs + 2);
        chk("to_sent3", 32'(sent[bs+1]), 32'h33);

        // Owner withdraws valid while in SEND.
        do_reset;
        push(1, 1'b1, 8'h42);
        tick;
        chk("dv_grant", 32'(grant), 32'h2);
        chk("dv_ready", 32'(req_ready), 32'h2);
        force_off[1] = 1'b1;
        #1;
        chk("dv_ready_drop", 32'(req_ready), 32'd0);
        tick;
        chk("dv_no_dv", 32'(tx_dv), 32'd0);
        chk("dv_hold_grant", 32'(grant), 32'h2);
        chk("dv_hold_ready", 32'(req_ready), 32'd0);
        tick;
        chk("dv_no_dv2", 32'(tx_dv), 32'd0);
        force_off[1] = 1'b0;
        tick;
        chk("dv_resend_ready", 32'(req_ready), 32'h2);
        tick;
        chk("dv_resend_dv", 32'(tx_dv), 32'd1);
        chk("dv_resend_byte", 32'(tx_byte), 32'h42);

        // Asynchronous reset in the middle of a byte.
        do_reset;
        bs = sent.size();
        push(1, 1'b1, 8'h61);
        wait_sent("rm_a", bs + 1);
        wait_done("rm_a");
        tick;
        push(2, 1'b1, 8'h62);
        wait_sent("rm_b", bs + 2);
        tick;
        chk("rm_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_grant", 32'(grant), 32'd0);
        chk("rm_ready", 32'(req_ready), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_byte", 32'(tx_byte), 32'd0);
        chk("rm_dv", 32'(tx_dv), 32'd0);
        chk("rm_timeout", 32'(timeout), 32'd0);
        push(0, 1'b1, 8'h60);
        push(3, 1'b1, 8'h63);
        tick;
        rst = 1'b0;
        tick;
        chk("rm_prio", 32'(grant), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
